// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the memory-port arbiter.
//   - FSM state encoding (DRAIN / IDLE / BUSY)
//   - NREQ_MAX: largest supported requester count
//   - clog2 / idx_w: width helpers for requester indices
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_DRAIN = 2'd0;
  localparam arb_state_t ST_IDLE  = 2'd1;
  localparam arb_state_t ST_BUSY  = 2'd2;

  localparam int NREQ_MAX = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // A requester index needs at least one bit even when clog2 would give zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: byte-wide link between the arbiter and the memory controller.
//   mem_addr  : byte address to memory.addr
//   mem_wdata : write data to memory.data_i
//   mem_rdata : read data from memory.data_o
//   mem_we    : write enable to memory.write_enable
//   mem_go    : start/hold request to memory.go
//   mem_done  : completion from memory.done
// master = arbiter side, slave = memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              mem_go;
  logic              mem_done;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_go,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_go,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner picker.
//   req   : pending requests
//   ptr   : round-robin search start (ignored in fixed-priority builds)
//   grant : one-hot winner, zero when no request
//   idx   : binary winner index, zero when no request
// MEM_ARB_ROUND_ROBIN_EN defined: search starts at ptr and wraps.
// Otherwise: lowest index wins.
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  int   c;
  logic found;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    found = 1'b0;
    c     = 0;
    // ptr is always < NREQ, so one subtraction is enough for the wrap.
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      cand = c[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
`else
    // Scan downward so the lowest set index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = i[IDX_W-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory controller port between NREQ
// requesters. Each requester holds a one-byte read or write request until
// it sees a one-cycle ack; read data is returned on rdata in the ack cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   req/req_we          : per-requester request level and write flag
//   req_addr/req_wdata  : packed per-requester address and write data
//   ack                 : one-hot completion pulse
//   rdata               : last read data, held between acks
//   busy                : high whenever the FSM is not in IDLE
//   mem                 : mem_arbiter_if.master towards the memory controller
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration,
// otherwise fixed priority (lowest index wins).
//
// state    | meaning
// DRAIN    | waiting for mem_done low before a new grant (reset state)
// IDLE     | no transfer, grant on any request
// BUSY     | mem_go high, fields frozen, waiting for mem_done
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  mem_arbiter_if.master          mem
);

  localparam int IDX_W = idx_w(NREQ);

  arb_state_t       state;
  logic [NREQ-1:0]  win_grant;
  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  mem_arb_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == ST_IDLE && |req) begin
      if (int'(pick_idx) == NREQ - 1) ptr <= '0;
      else                            ptr <= pick_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_DRAIN;
      ack           <= '0;
      rdata         <= '0;
      win_grant     <= '0;
      mem.mem_go    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_DRAIN: begin
          // Lets a transfer cut short by reset finish inside memory.
          if (!mem.mem_done) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (|req) begin
            mem.mem_addr  <= addr_arr[pick_idx];
            mem.mem_wdata <= wdata_arr[pick_idx];
            mem.mem_we    <= req_we[pick_idx];
            mem.mem_go    <= 1'b1;
            win_grant     <= pick_grant;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem.mem_done) begin
            if (!mem.mem_we) rdata <= mem.mem_rdata;
            ack        <= win_grant;
            mem.mem_go <= 1'b0;
            state      <= ST_DRAIN;
          end
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a memory stub
// and a transaction-level reference model (arbitration order, latched
// fields, read data, memory image).
module tb_mem_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NREQ-1:0]        req, req_we, ack;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem       (mif.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // requester-side model
  bit          pend    [NREQ];
  bit          t_we    [NREQ];
  logic [31:0] t_addr  [NREQ];
  logic [7:0]  t_wdata [NREQ];

  // transfer in flight and arbitration model
  int          mp;
  bit          in_flight;
  int          w;
  logic [31:0] e_addr;
  bit          e_we;
  logic [7:0]  e_wdata;
  logic [7:0]  model_mem [256];
  logic [7:0]  model_rdata;
  int          grant_log [$];

  // memory stub
  logic [7:0]  stub_mem [256];
  int sph, scnt, hcnt, lat_cfg, hold_cfg, lat_used;

  bit ack_due, rst_check, exp_grant_chk, exp_idle_chk, fall_chk;
  bit rst_at_done, scramble, gen_en, keep01;
  int go_run, cyc, fall_cyc, last_gap;

  task automatic new_txn(input int i, input bit we, input logic [31:0] a, input logic [7:0] d);
    pend[i]    = 1'b1;
    t_we[i]    = we;
    t_addr[i]  = a;
    t_wdata[i] = d;
    req[i]     = 1'b1;
    req_we[i]  = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic rand_txn(input int i);
    new_txn(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_000F, 8'($urandom));
  endtask

  // Winner from the set of pending requests, straight from the arbitration rule.
  function automatic int model_pick(input logic [NREQ-1:0] r);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (mp + k) % NREQ;
      if (r[j]) return j;
    end
`else
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  function automatic bit quiet();
    bit any;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) any |= pend[i];
    return !any && !in_flight && !ack_due && !rst_check && sph == 0 && busy === 1'b0;
  endfunction

  task automatic step_cycle();
    logic [NREQ-1:0] exp_ack;
    int wi;
    // In IDLE with a request present, the next edge must grant.
    exp_grant_chk = 1'b0;
    exp_idle_chk  = 1'b0;
    if (rst_n === 1'b1 && busy === 1'b0) begin
      if (|req) exp_grant_chk = 1'b1;
      else      exp_idle_chk  = 1'b1;
    end

    @(negedge clk);
    cyc++;
    if (mif.mem_go === 1'b1) go_run++;

    if (rst_check) begin
      check_eq("rst_go",    mif.mem_go,    0);
      check_eq("rst_we",    mif.mem_we,    0);
      check_eq("rst_addr",  mif.mem_addr,  0);
      check_eq("rst_wdata", mif.mem_wdata, 0);
      check_eq("rst_busy",  busy,          1);
      rst_check = 1'b0;
      rst_n     = 1'b1;
    end

    if (ack_due) begin
      if (e_we) model_mem[e_addr[7:0]] = e_wdata;
      else      model_rdata = model_mem[e_addr[7:0]];
      exp_ack    = '0;
      exp_ack[w] = 1'b1;
      check_eq("ack",     ack,        exp_ack);
      check_eq("go_drop", mif.mem_go, 0);
      check_eq("go_len",  go_run,     lat_used + 1);
      grant_log.push_back(w);
      pend[w]   = 1'b0;
      req[w]    = 1'b0;
      in_flight = 1'b0;
      ack_due   = 1'b0;
    end else begin
      check_eq("ack_idle", ack, 0);
    end
    check_eq("rdata", rdata, model_rdata);

    if (exp_grant_chk) begin
      check_eq("go_rise", mif.mem_go, 1);
      wi = model_pick(req);
      check_eq("grant_addr",  mif.mem_addr,  t_addr[wi]);
      check_eq("grant_we",    mif.mem_we,    t_we[wi]);
      check_eq("grant_wdata", mif.mem_wdata, t_wdata[wi]);
      w         = wi;
      e_addr    = t_addr[wi];
      e_we      = t_we[wi];
      e_wdata   = t_wdata[wi];
      in_flight = 1'b1;
      mp        = (wi + 1) % NREQ;
      go_run    = 1;
      last_gap  = cyc - fall_cyc;
    end else if (!in_flight) begin
      check_eq("go_spurious", mif.mem_go, 0);
    end
    if (in_flight) begin
      check_eq("frozen_go",    mif.mem_go,    1);
      check_eq("frozen_addr",  mif.mem_addr,  e_addr);
      check_eq("frozen_we",    mif.mem_we,    e_we);
      check_eq("frozen_wdata", mif.mem_wdata, e_wdata);
    end
    if (exp_idle_chk) check_eq("idle_stay", busy, 0);
    if (fall_chk) begin
      check_eq("drain_exit", busy, 0);
      fall_chk = 1'b0;
    end

    // memory stub
    mif.mem_rdata = 8'($urandom);
    case (sph)
      0: if (mif.mem_go === 1'b1 && mif.mem_done == 1'b0) begin
        scnt     = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
        lat_used = scnt;
        sph      = 1;
      end
      1: begin
        scnt--;
        if (scnt == 0) begin
          mif.mem_done = 1'b1;
          if (mif.mem_we) stub_mem[mif.mem_addr[7:0]] = mif.mem_wdata;
          else            mif.mem_rdata = stub_mem[mif.mem_addr[7:0]];
          sph = 2;
          if (rst_at_done) begin
            rst_n       = 1'b0;
            rst_check   = 1'b1;
            rst_at_done = 1'b0;
            in_flight   = 1'b0;
            mp          = 0;
            model_rdata = '0;
          end else begin
            ack_due = 1'b1;
          end
        end
      end
      2: begin
        hcnt = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 3));
        if (hcnt == 0) begin
          mif.mem_done = 1'b0; sph = 0; fall_chk = 1'b1; fall_cyc = cyc;
        end else begin
          sph = 3;
        end
      end
      default: begin
        hcnt--;
        if (hcnt == 0) begin
          mif.mem_done = 1'b0; sph = 0; fall_chk = 1'b1; fall_cyc = cyc;
        end
      end
    endcase

    // requesters
    if (scramble && in_flight) begin
      req_addr[w*ADDR_W +: ADDR_W]  = $urandom;
      req_wdata[w*DATA_W +: DATA_W] = 8'($urandom);
      req_we[w]                     = 1'($urandom_range(0, 1));
    end
    if (keep01) for (int i = 0; i < 2; i++) if (!pend[i]) rand_txn(i);
    if (gen_en) for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(0, 2) == 0) rand_txn(i);
  endtask

  task automatic wait_quiet(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (quiet()) break;
      step_cycle();
    end
    check_eq("drain_timeout", quiet(), 1);
  endtask

  initial begin
    int bad;
    int exp_w;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i) ^ 8'h5A;
      stub_mem[i]  = 8'(i) ^ 8'h5A;
    end
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
    end
    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mif.mem_done = 1'b0; mif.mem_rdata = '0;
    mp = 0; model_rdata = '0; in_flight = 1'b0; w = 0;
    e_addr = '0; e_we = 1'b0; e_wdata = '0;
    sph = 0; scnt = 0; hcnt = 0; lat_cfg = 5; hold_cfg = 0; lat_used = 0;
    ack_due = 1'b0; rst_check = 1'b1; fall_chk = 1'b0;
    rst_at_done = 1'b0; scramble = 1'b0; gen_en = 1'b0; keep01 = 1'b0;
    go_run = 0; cyc = 0; fall_cyc = 0; last_gap = 0;

    step_cycle();
    repeat (2) step_cycle();

    // single read, 5-cycle memory latency
    stub_mem[2] = 8'hA5; model_mem[2] = 8'hA5;
    new_txn(0, 1'b0, 32'h2, 8'h00);
    wait_quiet(40);
    check_eq("t1_rdata", rdata, 8'hA5);

    // single write from requester 1
    new_txn(1, 1'b1, 32'h10, 8'h3C);
    wait_quiet(40);
    check_eq("t2_rdata_kept", rdata, 8'hA5);
    check_eq("t2_mem", stub_mem[8'h10], 8'h3C);

    // requesters 0 and 1 continuously asserted
    lat_cfg = 0; hold_cfg = -1;
    grant_log.delete();
    keep01 = 1'b1;
    for (int k = 0; k < 200 && grant_log.size() < 6; k++) step_cycle();
    keep01 = 1'b0;
    check_eq("t3_count", grant_log.size() >= 6, 1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_w = k % 2;
`else
      exp_w = 0;
`endif
      check_eq("t3_seq", grant_log[k], exp_w);
    end
    wait_quiet(100);

    // mem_done held 4 cycles after go drops; second grant follows its fall
    lat_cfg = 2; hold_cfg = 4;
    new_txn(0, 1'b0, 32'h3, 8'h00);
    new_txn(1, 1'b1, 32'h4, 8'h77);
    wait_quiet(60);
    check_eq("t4_gap", last_gap, 2);

    // reset in the cycle mem_done arrives: no ack, request re-served later
    lat_cfg = 3; hold_cfg = 2;
    stub_mem[8'h80] = 8'hC3; model_mem[8'h80] = 8'hC3;
    grant_log.delete();
    rst_at_done = 1'b1;
    new_txn(0, 1'b0, 32'h80, 8'h00);
    wait_quiet(60);
    check_eq("t5_acks", grant_log.size(), 1);
    check_eq("t5_rdata", rdata, 8'hC3);

    // request fields change while the transfer is in flight
    lat_cfg = 4; hold_cfg = 0; scramble = 1'b1;
    new_txn(2, 1'b0, 32'h5, 8'h00);
    new_txn(0, 1'b1, 32'h6, 8'h99);
    wait_quiet(60);

    // random traffic
    lat_cfg = 0; hold_cfg = -1; gen_en = 1'b1;
    repeat (400) step_cycle();
    gen_en = 1'b0;
    wait_quiet(200);
    scramble = 1'b0;

    bad = 0;
    for (int i = 0; i < 256; i++) if (stub_mem[i] !== model_mem[i]) bad++;
    check_eq("mem_image", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
